// File: rtl/mux_tdm_pkg.sv
// Shared types and constants for the 8:1 TDM lane serializer.
// Lane count and select width match the 1:8 demux it feeds.
package mux_tdm_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/mux_eighttoone_tdm.sv
// Time-division 8:1 mux: captures a parallel word, then emits
// one (d, sel) lane pair per slot for the 1:8 demux.
module mux_eighttoone_tdm
  import mux_tdm_pkg::*;
#(
  parameter int NUM_LANES   = LANES,
  parameter int SEL_W       = mux_tdm_pkg::SEL_W,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] lanes_in,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 d_out,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 slot_valid,
  output logic                 frame_start,
  output logic                 frame_done
);

  localparam logic [3:0]       HOLD_MAX = 4'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_LANES - 1);

  state_t                 state_q, state_n;
  logic [NUM_LANES-1:0]   shadow_q, shadow_n;
  logic [3:0]             hold_q, hold_n;
  logic [SEL_W-1:0]       sel_q, sel_n, sel_inc;
  logic                   d_q, d_n;
  logic                   valid_q, valid_n;
  logic                   fs_q, fs_n;
  logic                   fd_q, fd_n;
  logic                   last_slot;
  logic                   accept;

  assign sel_inc   = sel_q + 1'b1;
  assign last_slot = (state_q == SEND) &&
                     (sel_q == SEL_MAX) &&
                     (hold_q == HOLD_MAX);
  // Gated by rst_n so the port reads 0 while reset is held.
  assign load_ready = rst_n &&
                      ((state_q == IDLE) || last_slot);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_n  = state_q;
    shadow_n = shadow_q;
    hold_n   = hold_q;
    sel_n    = sel_q;
    d_n      = d_q;
    valid_n  = valid_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          state_n  = SEND;
          shadow_n = lanes_in;
          hold_n   = '0;
          sel_n    = '0;
          d_n      = lanes_in[0];
          valid_n  = 1'b1;
        end
      end
      (state_q == SEND): begin
        if (hold_q != HOLD_MAX) begin
          hold_n = hold_q + 1'b1;
        end else if (sel_q != SEL_MAX) begin
          hold_n = '0;
          sel_n  = sel_inc;
          d_n    = shadow_q[sel_inc];
        end else if (load_valid) begin
          shadow_n = lanes_in;
          hold_n   = '0;
          sel_n    = '0;
          d_n      = lanes_in[0];
        end else begin
          state_n = IDLE;
          hold_n  = '0;
          sel_n   = '0;
          d_n     = 1'b0;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    fs_n = accept;
    // frame_done is registered, so predict the last cycle of slot 7.
    fd_n = (state_n == SEND) &&
           (sel_n == SEL_MAX) &&
           (hold_n == HOLD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      hold_q   <= '0;
      sel_q    <= '0;
      d_q      <= 1'b0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      shadow_q <= shadow_n;
      hold_q   <= hold_n;
      sel_q    <= sel_n;
      d_q      <= d_n;
      valid_q  <= valid_n;
      fs_q     <= fs_n;
      fd_q     <= fd_n;
    end
  end

  assign d_out       = d_q;
  assign sel_out     = sel_q;
  assign slot_valid  = valid_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_mux_eighttoone_tdm.sv
// Directed bench for mux_eighttoone_tdm at HOLD_CYCLES 1 and 3.
// Packed obs vector: {slot_valid, sel, d, frame_start, frame_done}.
module tb_mux_eighttoone_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lanes1 = '0, lanes3 = '0;
  logic       lv1 = 1'b0, lv3 = 1'b0;
  logic       rdy1, rdy3;
  logic       d1, d3;
  logic [2:0] sel1, sel3;
  logic       sv1, sv3, fs1, fs3, fd1, fd3;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  mux_eighttoone_tdm #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .lanes_in(lanes1),
    .load_valid(lv1), .load_ready(rdy1), .d_out(d1),
    .sel_out(sel1), .slot_valid(sv1),
    .frame_start(fs1), .frame_done(fd1)
  );

  mux_eighttoone_tdm #(.HOLD_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .lanes_in(lanes3),
    .load_valid(lv3), .load_ready(rdy3), .d_out(d3),
    .sel_out(sel3), .slot_valid(sv3),
    .frame_start(fs3), .frame_done(fd3)
  );

  wire [6:0] obs1 = {sv1, sel1, d1, fs1, fd1};
  wire [6:0] obs3 = {sv3, sel3, d3, fs3, fd3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({obs1, rdy1, obs3, rdy3} !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold obs1=%b rdy1=%b obs3=%b rdy3=%b required all 0",
               obs1, rdy1, obs3, rdy3);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({rdy1, sv1, rdy3, sv3} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release rdy1=%b sv1=%b rdy3=%b sv3=%b required 1 0 1 0",
               rdy1, sv1, rdy3, sv3);
    end
  endtask

  task automatic test_hold1();
    logic [7:0] w = 8'b1010_0101;
    logic [6:0] exp;
    lanes1 = w;
    lv1 = 1'b1;
    step();
    lv1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b1, 3'(k), w[k], k == 0, k == 7};
      checks++;
      if (obs1 !== exp || rdy1 !== (k == 7)) begin
        errors++;
        $display("FAIL hold1_slot%0d obs=%b rdy=%b required obs=%b rdy=%b",
                 k, obs1, rdy1, exp, k == 7);
      end
      step();
    end
    checks++;
    if (obs1 !== 7'b0 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL hold1_idle obs=%b rdy=%b required 0000000 1", obs1, rdy1);
    end
  endtask

  task automatic test_hold3();
    logic [6:0] exp;
    lanes3 = 8'h01;
    lv3 = 1'b1;
    step();
    lv3 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      exp = {1'b1, 3'(c / 3), c < 3, c == 0, c == 23};
      checks++;
      if (obs3 !== exp || rdy3 !== (c == 23)) begin
        errors++;
        $display("FAIL hold3_cyc%0d obs=%b rdy=%b required obs=%b rdy=%b",
                 c, obs3, rdy3, exp, c == 23);
      end
      step();
    end
    checks++;
    if (obs3 !== 7'b0) begin
      errors++;
      $display("FAIL hold3_idle obs=%b required 0000000", obs3);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    lanes1 = 8'hFF;
    lv1 = 1'b1;
    step();
    lanes1 = 8'h00;
    for (int c = 0; c < 16; c++) begin
      exp = {1'b1, 3'(c % 8), c < 8, (c % 8) == 0, (c % 8) == 7};
      checks++;
      if (obs1 !== exp) begin
        errors++;
        $display("FAIL b2b_cyc%0d obs=%b required %b", c, obs1, exp);
      end
      if (c == 8) lv1 = 1'b0;
      step();
    end
    checks++;
    if (sv1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle slot_valid=%b required 0", sv1);
    end
  endtask

  task automatic test_busy();
    lanes1 = 8'hFF;
    lv1 = 1'b1;
    step();
    lv1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) lanes1 = 8'h00;
      checks++;
      if ({sv1, sel1, d1} !== {1'b1, 3'(k), 1'b1}) begin
        errors++;
        $display("FAIL busy_slot%0d sv=%b sel=%0d d=%b required 1 %0d 1",
                 k, sv1, sel1, d1, k);
      end
      step();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] w = 8'h5A;
    logic [7:0] y, y_exp, seen;
    seen = '0;
    lanes1 = w;
    lv1 = 1'b1;
    step();
    lv1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      y = (sv1 && d1) ? (8'd1 << sel1) : 8'd0;
      y_exp = w[k] ? (8'd1 << k) : 8'd0;
      seen |= y;
      checks++;
      if (y !== y_exp) begin
        errors++;
        $display("FAIL loop_slot%0d y=%b required %b", k, y, y_exp);
      end
      step();
    end
    checks++;
    if (seen !== 8'b0101_1010) begin
      errors++;
      $display("FAIL loop_indices y_or=%b required 01011010", seen);
    end
  endtask

  task automatic test_reset_midframe();
    lanes1 = 8'hFF;
    lv1 = 1'b1;
    step();
    lv1 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs1, rdy1} !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid obs=%b rdy=%b required 0", obs1, rdy1);
    end
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs1 !== 7'b0 || rdy1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_after%0d obs=%b rdy=%b required 0000000 1",
                 c, obs1, rdy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold1();
    test_hold3();
    test_back_to_back();
    step();
    test_busy();
    step();
    test_loopback();
    step();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
